cond_exec_controller: RTL
=========================

Name: cond_exec_controller

Overview:
- Sequences conditional execution at the ID→EX boundary of the ARM pipeline.
- Owns the status register {Z,C,N,V} and tracks in-flight flag-setting (S) instructions.
- Stalls ID while a non-AL condition would read stale flags, then evaluates the condition and marks the instruction issued or squashed.
- After a taken branch, drives a fixed-length front-end flush.

Parameters:
- MAX_PENDING, 2, maximum number of S instructions allowed in flight with unreturned flags (≥1).
- FLUSH_CYCLES, 2, number of cycles branch_flush stays asserted after a taken branch (≥1).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  instruction present in ID
- id_cond  input  4  ARM condition field [31:28]
- id_set_flags  input  1  instruction has S bit
- id_is_branch  input  1  instruction is B/BL
- ex_flags_valid  input  1  ALU flag result returning this cycle
- ex_flags  input  4  returning flags {Z,C,N,V}
- hazard_stall  output  1  hold PC/IF/ID this cycle
- issue_valid  output  1  instruction enters EX and executes
- issue_squash  output  1  instruction enters EX as bubble (condition failed)
- branch_flush  output  1  flush IF/ID
- status_reg  output  4  architectural flags {Z,C,N,V}
- pending_cnt  output  $clog2(MAX_PENDING+1)  in-flight S instructions
- flag_err  output  1  sticky: flags returned with pending_cnt==0

Behaviour:
- Reset: synchronous, active-high.
  - Takes priority over all inputs, including mid-flush and mid-stall.
  - Values after reset: status_reg=0, pending_cnt=0, flag_err=0, state=RUN, flush counter=0, branch_flush=0.
- Condition function f(cond,Z,C,N,V):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 ~Z&(N==V); 1101 Z|(N!=V)
  - 1110 and 1111 always 1 (AL)
- States: RUN, FLUSH.
  - hazard_stall, issue_valid and issue_squash are combinational in RUN.
- Effective valid: ev = id_valid & (state==RUN).
- Hazard condition, either of:
  - ev & cond not AL & pending_cnt!=0
  - ev & id_set_flags & pending_cnt==MAX_PENDING & ~ex_flags_valid
- Outputs in RUN:
  - On hazard: hazard_stall=1, issue_valid=0, issue_squash=0.
  - Otherwise with ev: issue_valid = f(id_cond, status_reg); issue_squash = ~issue_valid.
  - At most one of hazard_stall, issue_valid, issue_squash is high per cycle.
- pending_cnt next value:
  - +1 when issue_valid & id_set_flags.
  - −1 when ex_flags_valid & pending_cnt!=0.
  - Both in the same cycle: unchanged.
  - Squashed S instructions never increment.
- ex_flags_valid:
  - status_reg ← ex_flags at the next edge, regardless of pending_cnt.
  - If pending_cnt==0: flag_err ← 1 and the counter stays 0.
- Transition RUN→FLUSH:
  - Trigger: issue_valid & id_is_branch.
  - Flush counter loads FLUSH_CYCLES.
  - branch_flush is registered and goes high in the first FLUSH cycle.
- FLUSH:
  - branch_flush=1; counter decrements each cycle; return to RUN when it reaches 1.
  - branch_flush is high for exactly FLUSH_CYCLES cycles.
  - ID inputs are ignored: hazard_stall=0, no issue.
  - Flag returns and pending_cnt updates continue as normal.
- Latency:
  - Issue decision in 0 cycles.
  - Flag update visible on status_reg 1 cycle after ex_flags_valid.
  - A stalled instruction issues in the cycle after the last pending flags return.

Optional Feature:
- Macro: FLAG_FWD_EN.
- When defined, forwarding applies if ex_flags_valid & pending_cnt==1 in the same cycle:
  - The hazard does not apply for a non-AL condition.
  - f() evaluates ex_flags instead of status_reg, so there is no stall cycle.
  - All other cases use status_reg.
- When undefined: the hazard rule above applies unchanged; the instruction stalls one cycle and evaluates against the updated status_reg.

Test Plan:
- Reset, then id_valid=1, id_cond=1110, id_is_branch=0 → issue_valid=1 same cycle; status_reg=0000; pending_cnt=0.
- ADDS issued (cond=1110, set_flags=1) → pending_cnt=1. Next cycle BEQ (cond=0000):
  - hazard_stall=1.
  - ex_flags_valid=1, ex_flags=1000 → status_reg=1000 next cycle.
  - Without FLAG_FWD_EN: stall clears, issue_valid=1, branch_flush high exactly 2 cycles.
  - With FLAG_FWD_EN: BEQ issues in the return cycle with no stall.
- status_reg=0100 (C=1,Z=0): cond 1000 → issue_valid; cond 1001 → issue_squash; cond 1011 with flags 0010 → issue_valid.
- Pending limit: two S instructions issued (pending_cnt=2), third S instruction with AL cond → hazard_stall=1 until ex_flags_valid, then issues with net pending_cnt=2.
- Mid-flush behaviour:
  - During FLUSH, id_valid=1, cond=1110 → no issue, hazard_stall=0.
  - rst=1 in first flush cycle → next cycle branch_flush=0, state RUN, pending_cnt=0.
- ex_flags_valid=1, ex_flags=0011 with pending_cnt=0 → status_reg=0011, flag_err=1 and sticky until rst.

Source files
------------

// File: rtl/cond_exec_controller.sv
// Conditional-execution sequencer at the ARM ID->EX boundary: owns {Z,C,N,V},
// tracks in-flight S instructions, stalls/issues/squashes, drives branch flush.
// Optional macro FLAG_FWD_EN: conditions evaluate flags returning in the same cycle.
module cond_exec_controller #(
  parameter int MAX_PENDING  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [3:0]                         id_cond,
  input  logic                               id_set_flags,
  input  logic                               id_is_branch,
  input  logic                               ex_flags_valid,
  input  logic [3:0]                         ex_flags,
  output logic                               hazard_stall,
  output logic                               issue_valid,
  output logic                               issue_squash,
  output logic                               branch_flush,
  output logic [3:0]                         status_reg,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               flag_err
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ONE   = PW'(1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state, state_d;
  logic [FW-1:0] flush_cnt, flush_cnt_d;
  logic [PW-1:0] pending_d;
  logic [3:0]    eval_flags;
  logic          ev, is_al, fwd, cond_haz, lim_haz, pass;
  logic          inc, dec;

  // Flags are packed {Z,C,N,V}: bit 3 is Z, bit 0 is V.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic z, c, n, v, r;
    z = flags[3];
    c = flags[2];
    n = flags[1];
    v = flags[0];
    r = 1'b1;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Issue decision: purely combinational so ID learns stall/issue/squash this cycle.
  // NOTE: every variable driven here gets a value on every path; a missing
  // assignment would infer a latch.
  always_comb begin
    ev    = id_valid && (state == RUN);
    is_al = &id_cond[3:1];
`ifdef FLAG_FWD_EN
    fwd   = ex_flags_valid && (pending_cnt == PEND_ONE);
`else
    fwd   = 1'b0;
`endif
    eval_flags   = fwd ? ex_flags : status_reg;
    cond_haz     = ev && !is_al && (pending_cnt != '0) && !fwd;
    lim_haz      = ev && id_set_flags && (pending_cnt == PEND_MAX) && !ex_flags_valid;
    hazard_stall = cond_haz || lim_haz;
    pass         = cond_pass(id_cond, eval_flags);
    issue_valid  = ev && !hazard_stall && pass;
    issue_squash = ev && !hazard_stall && !pass;
  end

  // Flush sequencing: counter counts FLUSH_CYCLES..1, one FLUSH cycle per value.
  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    case (state)
      RUN: begin
        if (issue_valid && id_is_branch) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_ONE) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt - FLUSH_ONE;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      flush_cnt    <= '0;
      branch_flush <= 1'b0;
    end else begin
      state        <= state_d;
      flush_cnt    <= flush_cnt_d;
      branch_flush <= (state_d == FLUSH);
    end
  end

  // Issue and return in the same cycle cancel; a stray return cannot underflow.
  always_comb begin
    inc = issue_valid && id_set_flags;
    dec = ex_flags_valid && (pending_cnt != '0);
    case ({inc, dec})
      2'b10:   pending_d = pending_cnt + PEND_ONE;
      2'b01:   pending_d = pending_cnt - PEND_ONE;
      default: pending_d = pending_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg  <= '0;
      pending_cnt <= '0;
      flag_err    <= 1'b0;
    end else begin
      pending_cnt <= pending_d;
      if (ex_flags_valid) begin
        status_reg <= ex_flags;
        if (pending_cnt == '0) flag_err <= 1'b1;
      end
    end
  end

endmodule
